// File: rtl/simon_playback_ctrl.sv
// simon_playback_ctrl: plays the stored Simon colour sequence onto one-hot LEDs
module simon_playback_ctrl #(
  parameter int MAX_LEN = 32,
  parameter int ON_CYCLES = 50_000_000,
  parameter int OFF_CYCLES = 25_000_000,
  parameter int CNT_W = 32,
  localparam int ADDR_W = $clog2(MAX_LEN),
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  seq_len,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic [3:0]        led,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, ADDR, LOAD, ON, OFF, DONE} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] led_q, led_d;
  logic last;
  assign last = LEN_W'(idx_q) == len_q - LEN_W'(1);
  assign rd_addr = addr_q;
  assign led = led_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  // state and datapath registers, cleared asynchronously so no LED survives reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      idx_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      led_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      idx_q <= idx_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end
  // next-state: abort overrides everything once playback has begun
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    idx_d = idx_q;
    len_d = len_q;
    cnt_d = cnt_q;
    led_d = led_q;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      led_d = '0;
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          if (seq_len == '0) state_d = DONE;
          else begin
            len_d = seq_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : seq_len;
            idx_d = '0;
            addr_d = '0;
            state_d = ADDR;
          end
        end
        ADDR: state_d = LOAD;
        LOAD: begin
          led_d = 4'b0001 << rd_data;
          cnt_d = CNT_W'(ON_CYCLES - 1);
          state_d = ON;
        end
        ON: if (cnt_q == '0) begin
          led_d = '0;
          cnt_d = CNT_W'(OFF_CYCLES - 1);
          state_d = OFF;
        end else cnt_d = cnt_q - CNT_W'(1);
        OFF: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else if (last) state_d = DONE;
        else begin
          idx_d = idx_q + ADDR_W'(1);
          addr_d = idx_q + ADDR_W'(1);
          state_d = ADDR;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
endmodule
